// File: rtl/h264_nz_store.sv
// CAVLC nC predictor: stores TotalCoeff of coded 4x4 blocks (left regs,
// top RAM) and forms the predicted nC two cycles after a block is addressed.
module h264_nz_store (
  input  logic       CLK,
  input  logic       NEWSLICE,
  input  logic       NEWLINE,
  input  logic       NLOAD,
  input  logic       NXINC,
  input  logic [2:0] NX,
  input  logic [2:0] NY,
  input  logic [1:0] NV,
  input  logic [4:0] NOUT,
  output logic [4:0] NIN
);

  logic [6:0] mbx_q, mbx_d;
  logic [2:0] nxd_q, nyd_q;
  logic [4:0] left_q [8];
  logic [4:0] top_mem [1024];

  logic [9:0] waddr, raddr;
  logic       we;

  logic [4:0] na_q, na_d;
  logic [1:0] nv_q;
  logic [4:0] ram_rd_q;
  logic       byp_q, byp_d;
  logic [4:0] bval_q;
  logic [4:0] nb;
  logic [5:0] sum6;
  logic [4:0] nin_q, nin_d;

  assign we    = NLOAD & ~NEWSLICE;
  assign waddr = {mbx_q, nxd_q};
  assign raddr = {mbx_q, NX};

  // NEWLINE wins over NXINC; counter wraps at 128
  always_comb begin
    mbx_d = mbx_q;
    if (NEWLINE)
      mbx_d = '0;
    else if (NXINC)
      mbx_d = mbx_q + 7'd1;
  end

  // Write-first bypass on both stores
  always_comb begin
    na_d  = left_q[NY];
    byp_d = 1'b0;
    if (NLOAD && (nyd_q == NY))
      na_d = NOUT;
    if (NLOAD && (waddr == raddr))
      byp_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (we)
      top_mem[waddr] <= NOUT;
  end

  always_ff @(posedge CLK) begin
    if (NEWSLICE)
      ram_rd_q <= '0;
    else
      ram_rd_q <= top_mem[raddr];
  end

  always_ff @(posedge CLK) begin
    if (NEWSLICE) begin
      mbx_q  <= '0;
      nxd_q  <= '0;
      nyd_q  <= '0;
      na_q   <= '0;
      nv_q   <= '0;
      byp_q  <= 1'b0;
      bval_q <= '0;
      nin_q  <= '0;
      for (int i = 0; i < 8; i++)
        left_q[i] <= '0;
    end else begin
      mbx_q  <= mbx_d;
      nxd_q  <= NX;
      nyd_q  <= NY;
      na_q   <= na_d;
      nv_q   <= NV;
      byp_q  <= byp_d;
      bval_q <= NOUT;
      nin_q  <= nin_d;
      if (NLOAD)
        left_q[nyd_q] <= NOUT;
    end
  end

  assign nb   = byp_q ? bval_q : ram_rd_q;
  assign sum6 = {1'b0, na_q} + {1'b0, nb} + 6'd1;

  always_comb begin
    nin_d = '0;
    case (nv_q)
      2'b01:   nin_d = na_q;
      2'b10:   nin_d = nb;
      2'b11:   nin_d = 5'(sum6 >> 1);
      default: nin_d = '0;
    endcase
  end

  assign NIN = nin_q;

endmodule

// File: tb/tb_h264_nz_store.sv
// Directed bench for h264_nz_store: store, predict, strobes, bypass, reset.
module tb_h264_nz_store;

  logic       CLK = 1'b0;
  logic       NEWSLICE, NEWLINE, NLOAD, NXINC;
  logic [2:0] NX, NY;
  logic [1:0] NV;
  logic [4:0] NOUT;
  logic [4:0] NIN;

  int n_chk  = 0;
  int n_fail = 0;

  h264_nz_store dut (
    .CLK      (CLK),
    .NEWSLICE (NEWSLICE),
    .NEWLINE  (NEWLINE),
    .NLOAD    (NLOAD),
    .NXINC    (NXINC),
    .NX       (NX),
    .NY       (NY),
    .NV       (NV),
    .NOUT     (NOUT),
    .NIN      (NIN)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input logic [2:0] nx, input logic [2:0] ny,
                     input logic [1:0] nv, input logic ld,
                     input logic [4:0] nout, input logic inc,
                     input logic nl, input logic rs);
    NX = nx; NY = ny; NV = nv; NLOAD = ld; NOUT = nout;
    NXINC = inc; NEWLINE = nl; NEWSLICE = rs;
    @(posedge CLK);
    #1;
  endtask

  task automatic pres(input logic [2:0] nx, input logic [2:0] ny,
                      input logic [1:0] nv);
    cyc(nx, ny, nv, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [2:0] nx, input logic [2:0] ny,
                      input logic [1:0] nv, input logic [4:0] v);
    cyc(nx, ny, nv, 1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic inc();
    cyc(3'd0, 3'd0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic nline();
    cyc(3'd0, 3'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    n_chk++;
    assert (NIN === exp) else begin
      n_fail++;
      $error("FAIL %s: NIN=%0d expected %0d", tag, NIN, exp);
    end
  endtask

  initial begin
    // reset
    cyc(3'd0, 3'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("reset", 5'd0);

    // left path, read coincides with write (bypass) then plain read
    pres(3'd0, 3'd0, 2'b00);
    load(3'd1, 3'd0, 2'b01, 5'd5);
    pres(3'd1, 3'd0, 2'b01);
    chk("left_byp", 5'd5);
    pres(3'd0, 3'd0, 2'b00);
    chk("left", 5'd5);
    pres(3'd0, 3'd0, 2'b00);
    chk("nv00", 5'd0);

    // average: left[0]=3, top[0,1]=6
    pres(3'd1, 3'd4, 2'b00);
    load(3'd0, 3'd0, 2'b00, 5'd6);
    load(3'd1, 3'd0, 2'b11, 5'd3);
    pres(3'd1, 3'd0, 2'b11);
    chk("avg_3_6_byp", 5'd5);
    pres(3'd0, 3'd0, 2'b00);
    chk("avg_3_6", 5'd5);

    // average 16,16 with both stores bypassed, then plain
    pres(3'd1, 3'd0, 2'b00);
    load(3'd1, 3'd0, 2'b11, 5'd16);
    pres(3'd1, 3'd0, 2'b11);
    chk("avg_16_byp", 5'd16);
    pres(3'd0, 3'd0, 2'b00);
    chk("avg_16", 5'd16);

    // row transition: mbx=2 writes x=2 NY=3 value 9
    inc(); inc();
    pres(3'd2, 3'd3, 2'b00);
    load(3'd0, 3'd0, 2'b00, 5'd9);
    nline(); inc(); inc();
    pres(3'd2, 3'd0, 2'b10);
    pres(3'd0, 3'd3, 2'b01);
    chk("row_top", 5'd9);
    pres(3'd0, 3'd0, 2'b00);
    chk("left_carry", 5'd9);

    // NEWLINE + NXINC -> mbx 0
    nline();
    pres(3'd3, 3'd1, 2'b00);
    load(3'd0, 3'd0, 2'b00, 5'd7);
    inc(); inc();
    pres(3'd3, 3'd1, 2'b00);
    load(3'd0, 3'd0, 2'b00, 5'd11);
    cyc(3'd0, 3'd0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    pres(3'd3, 3'd0, 2'b10);
    pres(3'd0, 3'd0, 2'b00);
    chk("nl_prio", 5'd7);

    // NLOAD + NXINC at mbx 7 uses the pre-update column
    repeat (7) inc();
    pres(3'd5, 3'd0, 2'b00);
    cyc(3'd0, 3'd0, 2'b00, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    pres(3'd5, 3'd0, 2'b00);
    load(3'd0, 3'd0, 2'b00, 5'd14);
    nline();
    repeat (7) inc();
    pres(3'd5, 3'd0, 2'b10);
    inc();
    chk("ld_inc_mbx7", 5'd13);
    pres(3'd5, 3'd0, 2'b10);
    pres(3'd0, 3'd0, 2'b00);
    chk("ld_inc_mbx8", 5'd14);

    // mbx wrap 127 -> 0
    nline();
    repeat (128) inc();
    pres(3'd3, 3'd0, 2'b10);
    pres(3'd0, 3'd0, 2'b00);
    chk("wrap", 5'd7);

    // left bypass: old left[1]=11, new 12
    pres(3'd0, 3'd1, 2'b00);
    load(3'd0, 3'd1, 2'b01, 5'd12);
    pres(3'd0, 3'd0, 2'b00);
    chk("bypass_l1", 5'd12);

    // out-of-contract NOUT kept unchanged
    pres(3'd0, 3'd2, 2'b00);
    load(3'd0, 3'd0, 2'b00, 5'd20);
    pres(3'd0, 3'd2, 2'b01);
    pres(3'd0, 3'd0, 2'b00);
    chk("nout20", 5'd20);

    // reset overriding NLOAD/NXINC mid-operation
    inc();
    pres(3'd0, 3'd1, 2'b00);
    cyc(3'd0, 3'd1, 2'b01, 1'b1, 5'd20, 1'b1, 1'b0, 1'b1);
    chk("rst_now", 5'd0);
    pres(3'd0, 3'd1, 2'b01);
    chk("rst_rel1", 5'd0);
    pres(3'd3, 3'd0, 2'b10);
    chk("rst_rel2_nowrite", 5'd0);
    pres(3'd0, 3'd2, 2'b01);
    chk("rst_mbx0_ram_kept", 5'd7);
    pres(3'd0, 3'd0, 2'b00);
    chk("rst_left2_clr", 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/h264_nz_store.md
H264_NZ_STORE -- requirements
Module: h264nzstore

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset, with the ports listed below (clock and reset first).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 NEWSLICE  input  1  reset; synchronous, active-high, start of slice.
REQ-004 NEWLINE  input  1  first macroblock of a new MB row.
REQ-005 NLOAD  input  1  strobe; the 4x4 block just coded has total-coeff count on NOUT.
REQ-006 NXINC  input  1  strobe; advance to next MB column.
REQ-007 NX  input  3  block X: luma {0,x1,x0}; chroma {1,cr,x}.
REQ-008 NY  input  3  block Y: luma {0,y1,y0}; chroma {1,cr,y}.
REQ-009 NV  input  2  neighbour-valid flags: bit0 = left, bit1 = top.
REQ-010 NOUT  input  5  TotalCoeff of the finished block, 0..16.
REQ-011 NIN  output  5  predicted nC for the block addressed by NX/NY/NV; reset 0.

Function
REQ-012 SHALL hold a left store of 8 x 5-bit registers indexed by NY[2:0] (luma rows 0-3, Cb/Cr rows 4-7).
REQ-013 SHALL hold a top store of 1024 x 5-bit synchronous RAM, address {mbx[6:0], NX[2:0]}, where mbx is a 7-bit MB column counter.
REQ-014 SHALL keep a 1-cycle-delayed copy of NX/NY (nxd/nyd); the block identity for an NLOAD write is nxd/nyd, not the current NX/NY.
REQ-015 On NLOAD=1: left[nyd] <= NOUT and top[{mbx,nxd}] <= NOUT, in the same cycle.
REQ-016 mbx update: NEWLINE=1 -> mbx <= 0; else NXINC=1 -> mbx <= mbx+1 (mod 128); else hold.
REQ-017 NEWLINE has priority over NXINC in the same cycle.
REQ-018 NLOAD coinciding with NXINC or NEWLINE SHALL write using the pre-update mbx.
REQ-019 Read stage 1: sample nA = left[NY] and NV into pipeline registers; issue RAM read at {mbx,NX}.
REQ-020 Read stage 2: register into NIN per NV:
  - 00 -> 0
  - 01 -> nA
  - 10 -> nB
  - 11 -> (nA+nB+1)>>1
REQ-021 Stage-2 averaging SHALL use a 6-bit sum; the result is at most 16 and is truncated to 5 bits.
REQ-022 Latency: NIN reflects the NX/NY/NV presented 2 cycles earlier; inputs change every cycle, so NIN updates every cycle.
REQ-023 Read-during-write: a read at stage 1 of an address being written by NLOAD in the same cycle SHALL return the new NOUT (write-first bypass, left and top).
REQ-024 Left store SHALL carry across MBs within a row (the right column of MB n becomes the left of MB n+1).
REQ-025 The top store row for mbx SHALL be overwritten by each MB row, so it always holds the bottom row of the MB above.
REQ-026 NV is authoritative: the block never derives validity itself, and stale RAM contents are never visible when NV gates them off.
REQ-027 Chroma DC blocks produce no NLOAD; the block SHALL write nothing for them.
REQ-028 An NOUT value > 16 is out of contract; the block SHALL store it unchanged (no saturation).

Reset
REQ-029 NEWSLICE=1 SHALL clear within one clock: mbx=0, left[0..7]=0, nxd/nyd=0, all pipeline registers=0, NIN=0.
REQ-030 NEWSLICE SHALL NOT clear RAM contents.
REQ-031 NEWSLICE SHALL override NLOAD, NXINC and NEWLINE in the same cycle: no write and no mbx change.
REQ-032 Reset mid-operation SHALL drop in-flight reads; NIN=0 for the 2 cycles following release.

Verification
REQ-033 Left path: NEWSLICE, then NX=0,NY=0 NOUT=5 NLOAD; then NX=1,NY=0,NV=01 -> NIN=5 two cycles later.
REQ-034 Average path: left[row0]=3, top[mbx=0,x=1]=6, NX=1,NY=0,NV=11 -> NIN=5; with values 16 and 16 -> NIN=16.
REQ-035 Row transition: mbx=2 writes luma x=2 NOUT=9 (NY=3); then NEWLINE, NXINC x2; NX=2,NY=0,NV=10 -> NIN=9.
REQ-036 Simultaneous strobes:
  - NLOAD+NXINC at mbx=7 -> write lands at mbx=7, next mbx=8.
  - NEWLINE+NXINC -> mbx=0.
  - mbx=127 + NXINC -> 0.
REQ-037 Bypass: NLOAD writes NOUT=12 to left[1] while stage 1 reads NY=1,NV=01 -> NIN=12, not the old value.
REQ-038 Reset: NEWSLICE asserted with NLOAD=1 and NXINC=1 -> no write (left stays 0), mbx=0, NIN=0 for 2 cycles after release.
